// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder.
// Contents:
//   DEFAULT_WIDTH / DEFAULT_STAGES - default geometry of the adder
//   signed_overflow()              - two's complement overflow from the MSB carries
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 2;

    // A signed result overflows exactly when the carry into the sign bit
    // differs from the carry out of it.
    function automatic logic signed_overflow(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// adder_stage: combinational CHUNK-bit adder slice used by every pipeline stage.
// Ports:
//   a, b   in   CHUNK  operand chunks (b already inverted for subtraction)
//   cin    in   1      carry from the previous chunk
//   sum    out  CHUNK  chunk sum
//   cout   out  1      carry out of the chunk MSB (inter-stage carry)
//   c_msb  out  1      carry into the chunk MSB (for signed overflow)
module adder_stage #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    // One bit wider than the chunk so the top bit is the carry out.
    logic [CHUNK:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = full[CHUNK-1:0];
    assign cout  = full[CHUNK];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of an XOR.
    assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES chunk stages with
// the carry registered between stages, valid/ready on both sides, one
// operation per cycle and a fixed latency of STAGES cycles.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   in_valid/ready   input handshake; in_ready = !(out_valid && !out_ready)
//   a, b             operands (unsigned or two's complement)
//   cin              carry-in, ignored when sub=1
//   sub              0: a+b+cin, 1: a-b
//   out_valid/ready  output handshake
//   sum              registered result
//   c_out            carry out of MSB (for subtraction 1 = no borrow)
//   overflow         signed overflow
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_split
        $error("pipelined_adder: WIDTH=%0d is not split evenly into STAGES=%0d", WIDTH, STAGES);
    end

    // The whole pipeline freezes while a finished result waits downstream;
    // this depends only on registered state and out_ready.
    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * CHUNK;     // low bits already summed
        localparam int REM = WIDTH - LO;    // operand bits still to add, this chunk included

        logic                v_in;
        logic [REM-1:0]      a_in;
        logic [REM-1:0]      b_in;
        logic                c_in;
        logic [CHUNK-1:0]    chunk_sum;
        logic                chunk_cout;
        logic                chunk_cmsb;
        logic [LO+CHUNK-1:0] s_out;         // completed low chunks, this one on top

        if (k == 0) begin : g_src
            // Subtraction is a + ~b + 1: invert b once here, force the carry-in.
            assign v_in  = in_valid;
            assign a_in  = a;
            assign b_in  = sub ? ~b : b;
            assign c_in  = sub | cin;
            assign s_out = chunk_sum;
        end else begin : g_src
            assign v_in  = g_stage[k-1].g_reg.v_q;
            assign a_in  = g_stage[k-1].g_reg.a_q;
            assign b_in  = g_stage[k-1].g_reg.b_q;
            assign c_in  = g_stage[k-1].g_reg.c_q;
            assign s_out = {chunk_sum, g_stage[k-1].g_reg.s_q};
        end

        adder_stage #(
            .CHUNK (CHUNK)
        ) u_stage (
            .a     (a_in[CHUNK-1:0]),
            .b     (b_in[CHUNK-1:0]),
            .cin   (c_in),
            .sum   (chunk_sum),
            .cout  (chunk_cout),
            .c_msb (chunk_cmsb)
        );

        if (k < STAGES - 1) begin : g_reg
            // Upper operand chunks ride along (skew) until their stage; the
            // finished low chunks ride along (de-skew) until the output.
            logic                v_q;
            logic                c_q;
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;
            logic [LO+CHUNK-1:0]  s_q;
            logic                 unused_cmsb;

            // Only the last stage looks at the sign-bit carry.
            assign unused_cmsb = chunk_cmsb;

            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples its predecessor's value from before the edge.
            // NOTE: datapath registers are reset too, so the held outputs never
            // show X after reset even though they are don't-care while invalid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (!stall) begin
                    v_q <= v_in;
                    c_q <= chunk_cout;
                    a_q <= a_in[REM-1:CHUNK];
                    b_q <= b_in[REM-1:CHUNK];
                    s_q <= s_out;
                end
            end
        end else begin : g_out
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    c_out     <= 1'b0;
                    overflow  <= 1'b0;
                end else if (!stall) begin
                    out_valid <= v_in;
                    sum       <= s_out;
                    c_out     <= chunk_cout;
                    overflow  <= signed_overflow(chunk_cmsb, chunk_cout);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder.
// Instance u_dut0 (WIDTH=8, STAGES=2) gets directed vectors, a back-to-back
// burst, a stall window and a mid-stream reset. Instances in g_rand
// (16/4 and 8/1) get randomized traffic with random backpressure.
// Expected results are queued at issue time and compared by monitors that
// pop whenever a result transfers out.
module tb_pipelined_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          issue_edge;
        int          stall_mark;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    localparam vec_t DIR [6] = '{
        '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
        '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
        '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0},
        '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0}
    };

    localparam int N_RAND = 400;

    logic clk = 1'b0;
    logic rst;
    bit   rand_go;
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                       input logic cin, input logic sub);
        exp_t   e;
        longint m, ua, ub, sa, sb, full, r;
        m  = longint'(1) << w;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (sub) begin
            full   = ua - ub + m;
            e.cout = (ua >= ub);
            r      = sa - sb;
        end else begin
            full   = ua + ub + longint'(cin);
            e.cout = (full >= m);
            r      = sa + sb + longint'(cin);
        end
        e.sum        = 16'(full % m);
        e.ovf        = (r < -(m / 2)) || (r >= m / 2);
        e.issue_edge = 0;
        e.stall_mark = 0;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Directed instance: WIDTH=8, STAGES=2
    // ------------------------------------------------------------------
    logic       d_in_valid, d_in_ready, d_cin, d_sub;
    logic       d_out_valid, d_out_ready, d_c_out, d_ovf;
    logic [7:0] d_a, d_b, d_sum;

    pipelined_adder #(
        .WIDTH  (8),
        .STAGES (2)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .a         (d_a),
        .b         (d_b),
        .cin       (d_cin),
        .sub       (d_sub),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .sum       (d_sum),
        .c_out     (d_c_out),
        .overflow  (d_ovf)
    );

    exp_t       q0 [$];
    int         stall_cnt0 = 0;
    int         run0 = 0;
    int         max_run0 = 0;
    int         ready_low0 = 0;
    int         pops0 = 0;
    bit         prev_stall0 = 1'b0;
    logic [9:0] held0;

    always @(negedge clk) begin
        exp_t e;
        run0 = d_out_valid ? run0 + 1 : 0;
        if (run0 > max_run0) max_run0 = run0;
        if (!d_in_ready) ready_low0++;
        if (prev_stall0 && d_out_valid)
            check("dut0_stall_hold", 32'({d_c_out, d_ovf, d_sum}), 32'(held0));
        prev_stall0 = d_out_valid && !d_out_ready;
        if (prev_stall0) begin
            stall_cnt0++;
            held0 = {d_c_out, d_ovf, d_sum};
        end
        if (d_out_valid && d_out_ready) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_result", 32'({d_c_out, d_ovf, d_sum}), 32'h1_0000);
            end else begin
                e = q0.pop_front();
                pops0++;
                check("dut0_sum", 32'(d_sum), 32'(e.sum[7:0]));
                check("dut0_c_out", 32'(d_c_out), 32'(e.cout));
                check("dut0_overflow", 32'(d_ovf), 32'(e.ovf));
                if (e.stall_mark == stall_cnt0)
                    check("dut0_latency", 32'(edge_cnt - e.issue_edge), 32'd2);
            end
        end
    end

    // Holds the operands until they are taken; returns at posedge+1.
    task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, input exp_t e);
        int waited = 0;
        d_in_valid = 1'b1;
        d_a = a;
        d_b = b;
        d_cin = cin;
        d_sub = sub;
        @(negedge clk);
        while (!d_in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!d_in_ready) begin
            check("dut0_in_ready_timeout", 32'(d_in_ready), 32'd1);
        end else begin
            e.issue_edge = edge_cnt;
            e.stall_mark = stall_cnt0;
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
    endtask

    task automatic issue0_rand();
        logic [7:0] a, b;
        logic       cin, sub;
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        issue0(a, b, cin, sub, ref_model(8, 16'(a), 16'(b), cin, sub));
    endtask

    // ------------------------------------------------------------------
    // Randomized instances: 16/4 and 8/1
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int    W   = (g == 0) ? 16 : 8;
        localparam int    S   = (g == 0) ? 4 : 1;
        localparam string TAG = (g == 0) ? "w16s4" : "w8s1";

        logic         in_valid, in_ready, cin, sub;
        logic         out_valid, out_ready, c_out, ovf;
        logic [W-1:0] a, b, sum;
        exp_t         q [$];
        bit           done = 1'b0;
        bit           prev_stall = 1'b0;
        logic [W+1:0] held;

        pipelined_adder #(
            .WIDTH  (W),
            .STAGES (S)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .c_out     (c_out),
            .overflow  (ovf)
        );

        // Bias towards boundary operands: zero, all ones, sign bit alone, max positive.
        function automatic logic [W-1:0] pick();
            logic [W-1:0] v;
            case ($urandom_range(0, 5))
                0:       v = '0;
                1:       v = '1;
                2:       v = {1'b1, {(W-1){1'b0}}};
                3:       v = {1'b0, {(W-1){1'b1}}};
                default: v = W'($urandom);
            endcase
            return v;
        endfunction

        initial begin
            int sent = 0;
            bit take = 1'b0;
            in_valid  = 1'b0;
            a         = '0;
            b         = '0;
            cin       = 1'b0;
            sub       = 1'b0;
            out_ready = 1'b1;
            wait (rand_go);
            @(posedge clk);
            #1;
            for (int cyc = 0; cyc < 20000 && sent < N_RAND; cyc++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (!in_valid && $urandom_range(0, 3) != 0) begin
                    a        = pick();
                    b        = pick();
                    cin      = 1'($urandom);
                    sub      = 1'($urandom);
                    in_valid = 1'b1;
                end
                @(negedge clk);
                take = in_valid && in_ready;
                if (take) begin
                    q.push_back(ref_model(W, 16'(a), 16'(b), cin, sub));
                    sent++;
                end
                @(posedge clk);
                #1;
                if (take) in_valid = 1'b0;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
            #1;
            check({TAG, "_ops_sent"}, 32'(sent), 32'(N_RAND));
            check({TAG, "_drained"}, 32'(q.size()), 32'd0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            exp_t e;
            if (prev_stall && out_valid)
                check({TAG, "_stall_hold"}, 32'({c_out, ovf, sum}), 32'(held));
            prev_stall = out_valid && !out_ready;
            if (prev_stall) held = {c_out, ovf, sum};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check({TAG, "_unexpected_result"}, 32'({c_out, ovf, sum}), 32'h10_0000);
                end else begin
                    e = q.pop_front();
                    check({TAG, "_sum"}, 32'(sum), 32'(e.sum[W-1:0]));
                    check({TAG, "_c_out"}, 32'(c_out), 32'(e.cout));
                    check({TAG, "_overflow"}, 32'(ovf), 32'(e.ovf));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int pops_before;
        d_in_valid  = 1'b0;
        d_a         = '0;
        d_b         = '0;
        d_cin       = 1'b0;
        d_sub       = 1'b0;
        d_out_ready = 1'b1;
        rand_go     = 1'b0;
        rst         = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_out_valid", 32'(d_out_valid), 32'd0);
        check("reset_sum", 32'(d_sum), 32'd0);
        check("reset_c_out", 32'(d_c_out), 32'd0);
        check("reset_overflow", 32'(d_ovf), 32'd0);
        check("reset_in_ready", 32'(d_in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors from the datasheet, issued back to back.
        foreach (DIR[i]) begin
            exp_t e;
            e.sum  = 16'(DIR[i].s);
            e.cout = DIR[i].c;
            e.ovf  = DIR[i].o;
            issue0(DIR[i].a, DIR[i].b, DIR[i].cin, DIR[i].sub, e);
        end
        repeat (5) @(posedge clk);
        #1;
        check("directed_drained", 32'(q0.size()), 32'd0);

        // Four back-to-back operations with the sink always ready.
        max_run0   = 0;
        ready_low0 = 0;
        repeat (4) issue0_rand();
        repeat (5) @(posedge clk);
        #1;
        check("burst_out_valid_run", 32'(max_run0), 32'd4);
        check("burst_in_ready_low_cycles", 32'(ready_low0), 32'd0);

        // Three operations into a stalled sink, then release.
        pops_before = pops0;
        fork
            begin
                repeat (3) issue0_rand();
            end
            begin
                d_out_ready = 1'b0;
                repeat (6) @(negedge clk);
                check("stall_in_ready", 32'(d_in_ready), 32'd0);
                check("stall_out_valid", 32'(d_out_valid), 32'd1);
                @(posedge clk);
                #1;
                d_out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("stall_results_delivered", 32'(pops0 - pops_before), 32'd3);
        check("stall_drained", 32'(q0.size()), 32'd0);

        // Reset with two operations in flight: outputs clear without a clock edge.
        issue0_rand();
        issue0_rand();
        #1 rst = 1'b1;
        #1;
        check("midreset_out_valid", 32'(d_out_valid), 32'd0);
        check("midreset_outputs", 32'({d_c_out, d_ovf, d_sum}), 32'd0);
        q0.delete();
        pops_before = pops0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postreset_in_ready", 32'(d_in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("postreset_no_stale", 32'(pops0 - pops_before), 32'd0);

        // Randomized sweep on the other two geometries.
        rand_go = 1'b1;
        for (int i = 0; i < 40000 && !(g_rand[0].done && g_rand[1].done); i++) @(posedge clk);
        #1;
        check("random_sweeps_finished", 32'({g_rand[0].done, g_rand[1].done}), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
